// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register-file slave.
//   RESP_OKAY / RESP_SLVERR : response codes driven on bresp / rresp
//   wr_state_t              : write-channel FSM states
//   rd_state_t              : read-channel FSM states
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_regfile_mem.sv
// DEPTH x DATA_W register array with one synchronous write port, one
// registered read port and a synchronous clear.
//   clk    : clock, rising edge
//   clear  : synchronous clear of every register and of rdata
//   we     : write enable; writes to waddr >= DEPTH are dropped
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates only when re is high
//   raddr  : read address; raddr >= DEPTH reads as zero
//   rdata  : registered read data, held while re is low
module axil_regfile_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = (32'(waddr) < DEPTH);
  assign rd_ok = (32'(raddr) < DEPTH);

  // Read and write share one block so a same-edge read sees the old value.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (re) begin
        rdata <= rd_ok ? regs[raddr[IDX_W-1:0]] : '0;
      end
      if (we && wr_ok) begin
        regs[waddr[IDX_W-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite-style register-file slave with independent AW/W/B and AR/R
// channels. All outputs are registered.
//   clk, rst_n               : clock and synchronous active-low reset
//   s_aw*, s_w*, s_b*        : write address, write data, write response
//   s_ar*, s_r*              : read address, read data
// Build option: define AXIL_REGFILE_ERR_RESP_EN to answer out-of-range
// accesses with SLVERR; otherwise they answer OKAY. Out-of-range writes are
// always dropped and out-of-range reads always return zero.
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready
);

`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;

  logic              aw_hs, w_hs, ar_hs;
  logic              commit;
  logic [ADDR_W-1:0] cmt_addr;
  logic [DATA_W-1:0] cmt_data;
  logic [1:0]        cmt_resp;
  logic [1:0]        ar_resp;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // Commit address/data come from the bus or from whichever half was latched.
  always_comb begin
    commit   = 1'b0;
    cmt_addr = s_awaddr;
    cmt_data = s_wdata;
    case (wr_state)
      WR_IDLE:    commit = aw_hs && w_hs;
      WR_WAIT_W: begin
        commit   = w_hs;
        cmt_addr = aw_addr_q;
      end
      WR_WAIT_AW: begin
        commit   = aw_hs;
        cmt_data = w_data_q;
      end
      default:    commit = 1'b0;
    endcase
  end

  assign cmt_resp = (32'(cmt_addr) < DEPTH) ? RESP_OKAY : OOR_RESP;
  assign ar_resp  = (32'(s_araddr) < DEPTH) ? RESP_OKAY : OOR_RESP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state  <= WR_IDLE;
      s_awready <= 1'b1;
      s_wready  <= 1'b1;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state  <= WR_RESP;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= cmt_resp;
          end else if (aw_hs) begin
            wr_state  <= WR_WAIT_W;
            aw_addr_q <= s_awaddr;
            s_awready <= 1'b0;
          end else if (w_hs) begin
            wr_state  <= WR_WAIT_AW;
            w_data_q  <= s_wdata;
            s_wready  <= 1'b0;
          end
        end
        WR_WAIT_W: begin
          if (w_hs) begin
            wr_state <= WR_RESP;
            s_wready <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= cmt_resp;
          end
        end
        WR_WAIT_AW: begin
          if (aw_hs) begin
            wr_state  <= WR_RESP;
            s_awready <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= cmt_resp;
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            wr_state  <= WR_IDLE;
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state  <= RD_DATA;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rresp   <= ar_resp;
          end
        end
        RD_DATA: begin
          if (s_rready) begin
            rd_state  <= RD_IDLE;
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  axil_regfile_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .clear (!rst_n),
    .we    (commit),
    .waddr (cmt_addr),
    .wdata (cmt_data),
    .re    (ar_hs),
    .raddr (s_araddr),
    .rdata (s_rdata)
  );

endmodule

// File: tb/tb_axil_regfile_slave.sv
module tb_axil_regfile_slave;

`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s_awaddr;
  logic       s_awvalid;
  logic       s_awready;
  logic [7:0] s_wdata;
  logic       s_wvalid;
  logic       s_wready;
  logic [1:0] s_bresp;
  logic       s_bvalid;
  logic       s_bready;
  logic [3:0] s_araddr;
  logic       s_arvalid;
  logic       s_arready;
  logic [7:0] s_rdata;
  logic [1:0] s_rresp;
  logic       s_rvalid;
  logic       s_rready;

  always #5 clk = ~clk;

  axil_regfile_slave #(
    .ADDR_W (4),
    .DATA_W (8),
    .DEPTH  (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready)
  );

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [1:0] exp_resp;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] r;
  } rexp_t;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] bq[$];
  rexp_t      rq[$];
  vec_t       vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present AW and/or W and hold each until it transfers.
  task automatic send_aw_w(input bit aw_en, input bit w_en, input logic [3:0] addr,
                           input logic [7:0] data);
    bit aw_done = !aw_en;
    bit w_done  = !w_en;
    bit a, w;
    s_awaddr  = addr;
    s_wdata   = data;
    s_awvalid = aw_en;
    s_wvalid  = w_en;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      a = s_awvalid && s_awready;
      w = s_wvalid && s_wready;
      @(posedge clk);
      #1;
      if (a) begin s_awvalid = 1'b0; aw_done = 1'b1; end
      if (w) begin s_wvalid = 1'b0; w_done = 1'b1; end
    end
    if (!(aw_done && w_done)) begin
      check("aw_w_timeout", 0, 1);
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
    end
  endtask

  task automatic issue_ar(input logic [3:0] addr);
    bit done = 1'b0;
    bit h;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      h = s_arready;
      @(posedge clk);
      #1;
      if (h) begin s_arvalid = 1'b0; done = 1'b1; end
    end
    if (!done) begin
      check("ar_timeout", 0, 1);
      s_arvalid = 1'b0;
    end
  endtask

  task automatic collect_b(input bit chk_lat);
    bit         got = 1'b0;
    logic [1:0] e;
    s_bready = 1'b1;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (s_bvalid) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          e = bq.pop_front();
          check("bresp", s_bresp, e);
        end
        if (chk_lat) check("b_latency", cyc, 0);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("b_timeout", 0, 1);
    s_bready = 1'b0;
  endtask

  task automatic collect_r(input bit chk_lat);
    bit    got = 1'b0;
    rexp_t e;
    s_rready = 1'b1;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (s_rvalid) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          check("rdata", s_rdata, e.d);
          check("rresp", s_rresp, e.r);
        end
        if (chk_lat) check("r_latency", cyc, 0);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("r_timeout", 0, 1);
    s_rready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [7:0] data, input logic [1:0] resp);
    bq.push_back(resp);
    send_aw_w(1'b1, 1'b1, addr, data);
    collect_b(1'b1);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [7:0] d, input logic [1:0] resp);
    rq.push_back('{d: d, r: resp});
    issue_ar(addr);
    collect_r(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  8'hA5, 8'h00, 2'b00};
    vecs[1]  = '{1'b0, 4'd3,  8'h00, 8'hA5, 2'b00};
    vecs[2]  = '{1'b1, 4'd11, 8'h5A, 8'h00, 2'b00};
    vecs[3]  = '{1'b0, 4'd11, 8'h00, 8'h5A, 2'b00};
    vecs[4]  = '{1'b1, 4'd13, 8'hFF, 8'h00, OOR};
    vecs[5]  = '{1'b0, 4'd13, 8'h00, 8'h00, OOR};
    vecs[6]  = '{1'b1, 4'd12, 8'h77, 8'h00, OOR};
    vecs[7]  = '{1'b0, 4'd12, 8'h00, 8'h00, OOR};
    vecs[8]  = '{1'b0, 4'd0,  8'h00, 8'h00, 2'b00};
    vecs[9]  = '{1'b1, 4'd0,  8'hC3, 8'h00, 2'b00};
    vecs[10] = '{1'b0, 4'd0,  8'h00, 8'hC3, 2'b00};
    vecs[11] = '{1'b0, 4'd15, 8'h00, 8'h00, OOR};

    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
    check("rst_valids", {s_bvalid, s_rvalid}, 2'b00);
    check("rst_resps", {s_bresp, s_rresp}, 4'b0000);
    check("rst_rdata", s_rdata, 8'h00);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_resp);
      else               do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // W leads AW by two cycles.
    send_aw_w(1'b0, 1'b1, 4'd0, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wait_aw_wready", s_wready, 1'b0);
      check("wait_aw_awready", s_awready, 1'b1);
      check("wait_aw_bvalid", s_bvalid, 1'b0);
      @(posedge clk); #1;
    end
    bq.push_back(2'b00);
    send_aw_w(1'b1, 1'b0, 4'd7, 8'h00);
    collect_b(1'b1);
    do_read(4'd7, 8'h3C, 2'b00);

    // Read backpressure: rready low for 4 cycles.
    do_write(4'd5, 8'h5E, 2'b00);
    rq.push_back('{d: 8'h5E, r: 2'b00});
    issue_ar(4'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_rvalid", s_rvalid, 1'b1);
      check("stall_rdata", s_rdata, 8'h5E);
      check("stall_arready", s_arready, 1'b0);
      @(posedge clk); #1;
    end
    collect_r(1'b0);
    @(negedge clk);
    check("post_r_rvalid", s_rvalid, 1'b0);
    check("post_r_arready", s_arready, 1'b1);
    @(posedge clk); #1;

    // Same-edge write commit and read of one address returns the old value.
    do_write(4'd2, 8'h22, 2'b00);
    bq.push_back(2'b00);
    rq.push_back('{d: 8'h22, r: 2'b00});
    s_awaddr = 4'd2; s_wdata = 8'h11; s_araddr = 4'd2;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    @(negedge clk);
    check("rbw_readies", {s_awready, s_wready, s_arready}, 3'b111);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    collect_b(1'b1);
    collect_r(1'b0);
    do_read(4'd2, 8'h11, 2'b00);

    // B stalled: no new write accepted, reads still complete; then reset.
    send_aw_w(1'b1, 1'b1, 4'd4, 8'h44);
    @(negedge clk);
    check("bstall_bvalid", s_bvalid, 1'b1);
    check("bstall_readies", {s_awready, s_wready}, 2'b00);
    @(posedge clk); #1;
    do_read(4'd3, 8'hA5, 2'b00);
    check("bstall_bvalid_held", s_bvalid, 1'b1);
    issue_ar(4'd4);
    @(negedge clk);
    check("pre_rst_valids", {s_bvalid, s_rvalid}, 2'b11);
    check("pre_rst_rdata", s_rdata, 8'h44);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valids", {s_bvalid, s_rvalid}, 2'b00);
    check("mid_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
    check("mid_rst_rdata", s_rdata, 8'h00);
    @(posedge clk); #1;
    bq.delete();
    rq.delete();
    for (int a = 0; a < 12; a++) begin
      do_read(4'(a), 8'h00, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
